fpu_share_sched: RTL

- Round-robin scheduler sharing one FPU core among NUM_REQ requesters.
- Accepts one operation at a time, pulses the FPU start, and waits for the FPU ready pulse or a timeout.
- Captures the result and the eight exception flags (ine, overflow, underflow, div_zero, inf, zero, qnan, snan), returns them to the granted requester and keeps per-requester sticky exception registers.
- Sits between the requester agents and the FPU_in/FPU_out interfaces of the FPU DUT.

---
 rtl/fpu_sched_pkg.sv | 32 +++
 rtl/fpu_share_sched_if.sv | 61 ++++++
 rtl/fpu_share_sched_rr_arbiter.sv | 42 ++++
 rtl/fpu_share_sched.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg: shared types for the FPU sharing scheduler.
//   fpu_flags_t   - the eight FPU exception flags, MSB first in FPU port order
//   sched_state_t - scheduler FSM states
//   merge_flags() - sticky-flag update rule (a clear in the capture cycle
//                   keeps only the fresh flags)
package fpu_sched_pkg;

    localparam int FLAG_W = 8;

    typedef struct packed {
        logic snan;
        logic qnan;
        logic zero;
        logic inf;
        logic div_zero;
        logic underflow;
        logic overflow;
        logic ine;
    } fpu_flags_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    function automatic fpu_flags_t merge_flags(fpu_flags_t old_f, fpu_flags_t new_f, logic clr);
        return clr ? new_f : fpu_flags_t'(old_f | new_f);
    endfunction

endpackage

// File: rtl/fpu_share_sched_if.sv
// fpu_share_sched_if: requester, FPU and response signals of the scheduler.
//   slave  - scheduler side (takes requests, drives the FPU, returns responses)
//   master - environment side (requesters, FPU core, response sink)
interface fpu_share_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    import fpu_sched_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_opa;
    logic [NUM_REQ*DATA_W-1:0] req_opb;
    logic [NUM_REQ*3-1:0]      req_op;
    logic [NUM_REQ*2-1:0]      req_rmode;

    logic                      fpu_start;
    logic [DATA_W-1:0]         fpu_opa;
    logic [DATA_W-1:0]         fpu_opb;
    logic [2:0]                fpu_op;
    logic [1:0]                fpu_rmode;
    logic                      fpu_ready;
    logic [DATA_W-1:0]         fpu_out;
    logic [FLAG_W-1:0]         fpu_flags;

    logic                      resp_valid;
    logic                      resp_ready;
    logic [ID_W-1:0]           resp_id;
    logic [DATA_W-1:0]         resp_data;
    logic [FLAG_W-1:0]         resp_flags;
    logic                      resp_timeout;

    logic [NUM_REQ-1:0]        sticky_clr;
    logic [NUM_REQ*FLAG_W-1:0] sticky_flags;
    logic [7:0]                stray_ready_cnt;

    modport slave (
        input  req_valid, req_opa, req_opb, req_op, req_rmode,
        output req_ready,
        output fpu_start, fpu_opa, fpu_opb, fpu_op, fpu_rmode,
        input  fpu_ready, fpu_out, fpu_flags,
        output resp_valid, resp_id, resp_data, resp_flags, resp_timeout,
        input  resp_ready,
        input  sticky_clr,
        output sticky_flags, stray_ready_cnt
    );

    modport master (
        output req_valid, req_opa, req_opb, req_op, req_rmode,
        input  req_ready,
        input  fpu_start, fpu_opa, fpu_opb, fpu_op, fpu_rmode,
        output fpu_ready, fpu_out, fpu_flags,
        input  resp_valid, resp_id, resp_data, resp_flags, resp_timeout,
        output resp_ready,
        output sticky_clr,
        input  sticky_flags, stray_ready_cnt
    );

endinterface

// File: rtl/fpu_share_sched_rr_arbiter.sv
// rr_arbiter: round-robin grant search.
//   i_req  - request vector
//   i_ptr  - highest-priority index (search starts here, wraps)
//   o_gnt  - one-hot grant
//   o_id   - encoded grant index
//   o_any  - at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_id,
    output logic               o_any
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    always_comb begin
        o_gnt = '0;
        o_id  = '0;
        o_any = 1'b0;
        w_sum = '0;
        w_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // i_ptr + k stays below 2*NUM_REQ, so one conditional subtract wraps it
            w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[ID_W-1:0];
            if (!o_any && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_id         = w_idx;
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_share_sched.sv
// fpu_share_sched: shares one FPU core among NUM_REQ requesters.
//   clk, rst - clock and synchronous active-high reset
//   bus      - slave modport of fpu_share_sched_if: per-requester requests,
//              FPU start/operands/result, response handshake, sticky flags,
//              stray fpu_ready counter
//
// state | meaning
// IDLE  | arbitrate; grant is acknowledged combinationally, operands captured
// ISSUE | one-cycle fpu_start, clear the wait counter
// WAIT  | wait for fpu_ready or TIMEOUT_CYCLES cycles
// RESP  | hold response until resp_ready, then advance round-robin pointer
module fpu_share_sched
    import fpu_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    fpu_share_sched_if.slave   bus
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_RESP  = RESP;

    logic [1:0]        r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [2:0]        r_op;
    logic [1:0]        r_rmode;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_resp_data;
    fpu_flags_t        r_resp_flags;
    logic              r_resp_timeout;
    fpu_flags_t        r_sticky [NUM_REQ];
    logic [7:0]        r_stray;

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_any;
    logic [DATA_W-1:0]  w_sel_opa;
    logic [DATA_W-1:0]  w_sel_opb;
    logic [2:0]         w_sel_op;
    logic [1:0]         w_sel_rmode;
    fpu_flags_t         w_fpu_flags;
    logic               w_capture;
    logic               w_expire;
    logic [ID_W-1:0]    w_next_ptr;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_id  (w_gnt_id),
        .o_any (w_any)
    );

    always_comb begin
        w_sel_opa   = '0;
        w_sel_opb   = '0;
        w_sel_op    = '0;
        w_sel_rmode = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_opa   = bus.req_opa[i*DATA_W +: DATA_W];
                w_sel_opb   = bus.req_opb[i*DATA_W +: DATA_W];
                w_sel_op    = bus.req_op[i*3 +: 3];
                w_sel_rmode = bus.req_rmode[i*2 +: 2];
            end
        end
    end

    assign w_fpu_flags = fpu_flags_t'(bus.fpu_flags);
    assign w_capture   = (r_state == ST_WAIT) && bus.fpu_ready;
    // ready in the expiry cycle wins, hence the !fpu_ready term
    assign w_expire    = (r_state == ST_WAIT) && !bus.fpu_ready &&
                         (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_next_ptr  = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_ptr          <= '0;
            r_id           <= '0;
            r_opa          <= '0;
            r_opb          <= '0;
            r_op           <= '0;
            r_rmode        <= '0;
            r_cnt          <= '0;
            r_resp_data    <= '0;
            r_resp_flags   <= '0;
            r_resp_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_id    <= w_gnt_id;
                        r_opa   <= w_sel_opa;
                        r_opb   <= w_sel_opb;
                        r_op    <= w_sel_op;
                        r_rmode <= w_sel_rmode;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_capture) begin
                        r_resp_data    <= bus.fpu_out;
                        r_resp_flags   <= w_fpu_flags;
                        r_resp_timeout <= 1'b0;
                        r_state        <= ST_RESP;
                    end else if (w_expire) begin
                        r_resp_data    <= '0;
                        r_resp_flags   <= '0;
                        r_resp_timeout <= 1'b1;
                        r_state        <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_sticky[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_capture && (r_id == ID_W'(i))) begin
                    r_sticky[i] <= merge_flags(r_sticky[i], w_fpu_flags, bus.sticky_clr[i]);
                end else if (bus.sticky_clr[i]) begin
                    r_sticky[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stray <= '0;
        end else if (bus.fpu_ready && (r_state != ST_WAIT) && (r_stray != 8'hFF)) begin
            r_stray <= r_stray + 8'd1;
        end
    end

    assign bus.req_ready       = (r_state == ST_IDLE) ? w_gnt : '0;
    assign bus.fpu_start       = (r_state == ST_ISSUE);
    assign bus.fpu_opa         = r_opa;
    assign bus.fpu_opb         = r_opb;
    assign bus.fpu_op          = r_op;
    assign bus.fpu_rmode       = r_rmode;
    assign bus.resp_valid      = (r_state == ST_RESP);
    assign bus.resp_id         = r_id;
    assign bus.resp_data       = r_resp_data;
    assign bus.resp_flags      = r_resp_flags;
    assign bus.resp_timeout    = r_resp_timeout;
    assign bus.stray_ready_cnt = r_stray;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_sticky
        assign bus.sticky_flags[g*FLAG_W +: FLAG_W] = r_sticky[g];
    end

endmodule
